// File: rtl/case_6_mul_share_arb.sv
// Round-robin arbiter in front of a shared signed A_W x B_W multiplier.
// NUM_REQ requesters offer operands on valid/ready ports; the winner is
// registered into S1, multiplied into S2, and S2 drives the single tagged
// valid/ready result port.
//
// Ports:
//   ap_clk     clock, rising edge
//   ap_rst     asynchronous active-high reset
//   req_valid  per-requester request valid
//   req_ready  per-requester accept, one-hot or zero
//   req_a      packed operand A, requester i at [i*A_W +: A_W]
//   req_b      packed operand B, requester i at [i*B_W +: B_W]
//   out_valid  result valid
//   out_ready  downstream accept
//   out_data   low OUT_W bits of the signed product
//   out_id     index of the requester that issued the result
//   busy       any stage occupied
module case_6_mul_share_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned A_W     = 13,
  parameter int unsigned B_W     = 7,
  parameter int unsigned OUT_W   = 13,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic [ID_W-1:0]        out_id,
  output logic                   busy
);

  localparam int unsigned P_W = A_W + B_W;

  // S1 operand register
  logic            s1_valid;
  logic [A_W-1:0]  s1_a;
  logic [B_W-1:0]  s1_b;
  logic [ID_W-1:0] s1_id;
  // S2 valid; S2 data lives directly in out_data/out_id
  logic            s2_valid;
  // Last granted requester; scanning starts just after it
  logic [ID_W-1:0] rr_ptr;

  logic            adv1;
  logic            adv2;
  logic            grant_any;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] scan_id;
  int unsigned     scan;
  logic            hs;
  logic [A_W-1:0]  sel_a;
  logic [B_W-1:0]  sel_b;

  logic signed [P_W-1:0]   sext_a;
  logic signed [P_W-1:0]   sext_b;
  logic        [OUT_W-1:0] prod_lo;

  assign adv2 = ~s2_valid | out_ready;
  assign adv1 = ~s1_valid | adv2;

  // Round-robin scan: rr_ptr+1, rr_ptr+2, ... wrapping at NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan      = 0;
    scan_id   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan    = (32'(rr_ptr) + k) % NUM_REQ;
      scan_id = ID_W'(scan);
      if (!grant_any && req_valid[scan_id]) begin
        grant_any = 1'b1;
        grant_id  = scan_id;
      end
    end
  end

  // Reset also masks ready so nothing is offered while the pipe is held clear.
  always_comb begin
    req_ready = '0;
    if (adv1 && grant_any && !ap_rst) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign hs    = |(req_valid & req_ready);
  assign sel_a = req_a[32'(grant_id) * A_W +: A_W];
  assign sel_b = req_b[32'(grant_id) * B_W +: B_W];

  // Full-width signed product; only the low OUT_W bits are kept (wrap-around).
  assign sext_a  = P_W'($signed(s1_a));
  assign sext_b  = P_W'($signed(s1_b));
  assign prod_lo = OUT_W'(sext_a * sext_b);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      out_data <= '0;
      out_id   <= '0;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
    end else begin
      // S1: load on handshake, drain to empty when free to move and nothing granted
      if (hs) begin
        s1_valid <= 1'b1;
        s1_a     <= sel_a;
        s1_b     <= sel_b;
        s1_id    <= grant_id;
        rr_ptr   <= grant_id;
      end else if (adv1) begin
        s1_valid <= 1'b0;
      end
      // S2: holds while the consumer stalls a valid result
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= prod_lo;
          out_id   <= s1_id;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_case_6_mul_share_arb.sv
module tb_case_6_mul_share_arb;

  localparam int N = 4;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [51:0] req_a = '0;
  logic [27:0] req_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [12:0] out_data;
  logic [1:0]  out_id;
  logic        busy;

  always #5 ap_clk = ~ap_clk;

  case_6_mul_share_arb #(
    .NUM_REQ(4),
    .A_W    (13),
    .B_W    (7),
    .OUT_W  (13)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_id   (out_id),
    .busy     (busy)
  );

  // Transaction-level model: in-flight results in grant order, each with
  // the number of clock edges since it was granted.
  typedef struct {
    int          id;
    logic [12:0] data;
    int          age;
  } item_t;

  item_t       q[$];
  int          rr;
  bit          pv[N];
  logic [12:0] pa[N];
  logic [6:0]  pb[N];
  int          checks;
  int          errors;
  int          obs_grant;
  int          pops;

  function automatic logic [12:0] ref_mul(logic [12:0] a, logic [6:0] b);
    logic signed [12:0] sa;
    logic signed [6:0]  sb;
    int                 p;
    sa = a;
    sb = b;
    p  = int'(sa) * int'(sb);
    return p[12:0];
  endfunction

  // At most two results in flight; a third is refused only if the head can't leave.
  function automatic int model_winner();
    int i;
    if (q.size() >= 2 && !out_ready) return -1;
    for (int k = 1; k <= N; k++) begin
      i = (rr + k) % N;
      if (pv[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = pv[i];
      req_a[i*13 +: 13]   = pa[i];
      req_b[i*7 +: 7]     = pb[i];
    end
  endtask

  task automatic set_req(input int i, input logic [12:0] a, input logic [6:0] b);
    pv[i] = 1'b1;
    pa[i] = a;
    pb[i] = b;
  endtask

  // One clock: drive, compare against the model, advance the model on the edge.
  task automatic step();
    int         w;
    bit         exp_ov;
    bit         pop;
    logic [3:0] exp_rdy;
    item_t      it;
    drive();
    #1;
    w       = model_winner();
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    exp_ov = (q.size() > 0) && (q[0].age >= 1);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("out_data", 32'(out_data), 32'(q[0].data));
      chk("out_id", 32'(out_id), 32'(q[0].id));
    end
    chk("busy", 32'(busy), 32'(q.size() > 0));
    obs_grant = -1;
    for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) obs_grant = i;
    pop = exp_ov && out_ready;
    @(posedge ap_clk);
    if (pop) begin
      void'(q.pop_front());
      pops++;
    end
    foreach (q[j]) q[j].age++;
    if (w >= 0) begin
      it.id   = w;
      it.data = ref_mul(pa[w], pb[w]);
      it.age  = 0;
      q.push_back(it);
      rr    = w;
      pv[w] = 1'b0;
    end
    @(negedge ap_clk);
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    drive();
    q.delete();
    rr = N - 1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int g = 0; g < 10 && q.size() > 0; g++) step();
  endtask

  function automatic logic [12:0] pick_a();
    int r = $urandom_range(0, 7);
    if (r == 0) return 13'h0FFF;
    if (r == 1) return 13'h1000;
    return 13'($urandom);
  endfunction

  function automatic logic [6:0] pick_b();
    int r = $urandom_range(0, 7);
    if (r == 0) return 7'h3F;
    if (r == 1) return 7'h40;
    return 7'($urandom);
  endfunction

  initial begin
    int sent;
    checks = 0;
    errors = 0;
    pops   = 0;
    rr     = N - 1;
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
      pb[i] = '0;
    end

    // Reset values, with requests pending so the ready mask is exercised
    set_req(2, 13'h0005, 7'h03);
    drive();
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_id", 32'(out_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    do_reset();

    // Single op from req0
    out_ready = 1'b1;
    set_req(0, 13'h1F9C, 7'd37);
    step();
    step();
    #1;
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_data", 32'(out_data), 32'h118C);
    chk("single_id", 32'(out_id), 32'h0);
    drain();

    // Overflow wrap
    set_req(0, 13'h0FFF, 7'h3F);
    step();
    set_req(0, 13'h1000, 7'h40);
    step();
    #1;
    chk("wrap_max", 32'(out_data), 32'h0FC1);
    step();
    #1;
    chk("wrap_min", 32'(out_data), 32'h0000);
    drain();

    // Round-robin with all requesters held
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) if (!pv[i]) set_req(i, pick_a(), pick_b());
      step();
      chk("rr_grant", 32'(obs_grant), 32'(k % N));
    end
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    drain();

    // Backpressure: 6 back-to-back ops from req2, consumer stalled cycles 3..7
    pops = 0;
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      if (sent < 6 && !pv[2]) begin
        set_req(2, pick_a(), pick_b());
        sent++;
      end
      out_ready = !(c >= 3 && c <= 7);
      step();
      if (sent == 6 && !pv[2] && q.size() == 0) break;
    end
    chk("bp_count", 32'(pops), 32'd6);

    // Fairness after idle
    do_reset();
    out_ready = 1'b1;
    set_req(1, 13'h0011, 7'h02);
    step();
    drain();
    set_req(1, 13'h0022, 7'h05);
    set_req(3, 13'h1333, 7'h7B);
    step();
    chk("fair_first", 32'(obs_grant), 32'd3);
    step();
    chk("fair_second", 32'(obs_grant), 32'd1);
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    set_req(0, 13'h0123, 7'h11);
    step();
    set_req(1, 13'h0456, 7'h22);
    step();
    for (int i = 0; i < N; i++) set_req(i, pick_a(), pick_b());
    drive();
    #1;
    chk("full_busy", 32'(busy), 32'h1);
    #2;
    ap_rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_req_ready", 32'(req_ready), 32'h0);
    q.delete();
    rr = N - 1;
    @(negedge ap_clk);
    ap_rst    = 1'b0;
    out_ready = 1'b1;
    step();
    chk("postrst_grant", 32'(obs_grant), 32'd0);
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    drain();

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 45) set_req(i, pick_a(), pick_b());
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
